// File: rtl/uart_tx.sv
// uart_tx: byte UART transmitter with one-entry holding register.
// Frame: start, 8 data LSB first, optional parity, 1 or 2 stop bits.
//
// Ports:
//   clk       in  1  clock
//   rst       in  1  asynchronous active-low reset
//   tx_data   in  8  byte to send, sampled on handshake
//   tx_valid  in  1  producer has a byte
//   tx_ready  out 1  holding register empty
//   tx        out 1  serial line, idle high, registered
//   tx_busy   out 1  frame in progress (aligned with tx)
//   tx_done   out 1  pulse in last cycle of the final stop bit

module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CNT_W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stop_q, stop_d;
  logic             par_q, par_d;
  logic [7:0]       hold_q, hold_d;
  logic             full_q, full_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic hs;
  logic cnt_last;
  logic frame_end;
  logic stop_more;

  assign hs        = tx_valid && !full_q;
  assign cnt_last  = (cnt_q == CNT_MAX);
  assign stop_more = (STOP_BITS == 2) && !stop_q;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    cnt_d     = cnt_last ? '0 : cnt_q + CNT_W'(1);
    stop_d    = stop_q;
    par_d     = par_q;
    hold_d    = hold_q;
    full_d    = full_q;
    frame_end = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (hs) begin
          shift_d = tx_data;
          par_d   = 1'b0;
          idx_d   = 3'd0;
          stop_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_last) begin
          idx_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          par_d   = par_q ^ shift_q[0];
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            stop_d  = 1'b0;
            state_d = PARITY_EN ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (cnt_last) begin
          stop_d  = 1'b0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_last) begin
          if (stop_more) begin
            stop_d = 1'b1;
          end else begin
            frame_end = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Chain the next frame straight from the stop bit:
    // a held byte has priority, else a byte offered right now.
    if (frame_end) begin
      par_d  = 1'b0;
      idx_d  = 3'd0;
      stop_d = 1'b0;
      if (full_q) begin
        shift_d = hold_q;
        full_d  = 1'b0;
        state_d = S_START;
      end else if (hs) begin
        shift_d = tx_data;
        state_d = S_START;
      end else begin
        state_d = S_IDLE;
      end
    end else if (hs && state_q != S_IDLE) begin
      hold_d = tx_data;
      full_d = 1'b1;
    end
  end

  // Line level follows the current state; registering it
  // delays tx, busy and done together by one cycle.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
      S_PARITY: tx_d = par_q ^ PARITY_ODD;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_q != S_IDLE);
    done_d = frame_end;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_ready = !full_q;
  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx at N=4 in four
// configurations (plain, even parity, odd parity, two stops).

module tb_uart_tx;

  localparam int NB = 4;
  localparam int SN = 130;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic [3:0] vld;
  logic [3:0] rdyv;
  logic [3:0] txv;
  logic [3:0] busyv;
  logic [3:0] donev;

  int total;
  int bad;

  typedef struct {
    int          inst;
    logic [7:0]  data;
    logic [11:0] frame;
    int          nbits;
  } vec_t;

  vec_t vt[9];

  logic lt[SN];
  logic ld[SN];
  logic lr[SN];

  uart_tx #(.CLKS_PER_BIT(NB), .PARITY_EN(1'b0),
            .PARITY_ODD(1'b0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_data(tx_data),
    .tx_valid(vld[0]), .tx_ready(rdyv[0]), .tx(txv[0]),
    .tx_busy(busyv[0]), .tx_done(donev[0]));

  uart_tx #(.CLKS_PER_BIT(NB), .PARITY_EN(1'b1),
            .PARITY_ODD(1'b0), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .tx_data(tx_data),
    .tx_valid(vld[1]), .tx_ready(rdyv[1]), .tx(txv[1]),
    .tx_busy(busyv[1]), .tx_done(donev[1]));

  uart_tx #(.CLKS_PER_BIT(NB), .PARITY_EN(1'b1),
            .PARITY_ODD(1'b1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .tx_data(tx_data),
    .tx_valid(vld[2]), .tx_ready(rdyv[2]), .tx(txv[2]),
    .tx_busy(busyv[2]), .tx_done(donev[2]));

  uart_tx #(.CLKS_PER_BIT(NB), .PARITY_EN(1'b0),
            .PARITY_ODD(1'b0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .tx_data(tx_data),
    .tx_valid(vld[3]), .tx_ready(rdyv[3]), .tx(txv[3]),
    .tx_busy(busyv[3]), .tx_done(donev[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act,
                      input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // One frame from idle; frame slot i is the line level
  // during bit period i (slot 0 = start bit).
  task automatic run_vec(input vec_t v, input int idx);
    int   nc;
    int   e_line;
    int   e_done;
    int   e_busy;
    logic expb;
    string nm;
    nm = $sformatf("vec%0d", idx);
    nc = NB * v.nbits;
    e_line = 0;
    e_done = 0;
    e_busy = 0;
    chk1({nm, "_ready"}, rdyv[v.inst], 1'b1);
    tx_data = v.data;
    vld[v.inst] = 1'b1;
    @(negedge clk);
    vld[v.inst] = 1'b0;
    tx_data = 8'h00;
    chk1({nm, "_lat_tx"}, txv[v.inst], 1'b1);
    chk1({nm, "_lat_busy"}, busyv[v.inst], 1'b0);
    @(negedge clk);
    for (int c = 0; c < nc; c++) begin
      expb = v.frame[c / NB];
      if (txv[v.inst] !== expb) e_line++;
      if (donev[v.inst] !== (c == nc - 1)) e_done++;
      if (busyv[v.inst] !== 1'b1) e_busy++;
      @(negedge clk);
    end
    chkn({nm, "_line_bad_cycles"}, e_line, 0);
    chkn({nm, "_done_bad_cycles"}, e_done, 0);
    chkn({nm, "_busy_bad_cycles"}, e_busy, 0);
    chk1({nm, "_post_tx"}, txv[v.inst], 1'b1);
    chk1({nm, "_post_busy"}, busyv[v.inst], 1'b0);
    chk1({nm, "_post_done"}, donev[v.inst], 1'b0);
  endtask

  // mode 0: three bytes, two queued, third held on valid.
  // mode 1: second byte offered on the stop-end edge.
  task automatic seq_test(input int mode);
    logic [7:0] bl[3];
    int   nf;
    int   exp_rlow;
    int   e_line;
    int   e_done;
    int   rlow;
    int   tmo;
    int   n;
    int   f;
    int   c;
    logic expb;
    logic expd;
    if (mode == 0) begin
      bl = '{8'h00, 8'hFF, 8'h96};
      nf = 3;
      // ready low from the cycle after each busy-time
      // handshake up to the drain edge: 39 cycles, twice
      exp_rlow = 78;
    end else begin
      bl = '{8'h81, 8'h3C, 8'h00};
      nf = 2;
      exp_rlow = 0;
    end
    tmo = 0;
    tx_data = bl[0];
    vld[0] = 1'b1;
    fork
      begin
        for (int s = 0; s < SN; s++) begin
          @(negedge clk);
          lt[s] = txv[0];
          ld[s] = donev[0];
          lr[s] = rdyv[0];
        end
      end
      begin
        if (mode == 0) begin
          @(negedge clk);
          tx_data = bl[1];
          @(negedge clk);
          tx_data = bl[2];
          n = 0;
          while (!rdyv[0] && n < 100) begin
            @(negedge clk);
            n++;
          end
          if (!rdyv[0]) tmo++;
          @(negedge clk);
          vld[0] = 1'b0;
        end else begin
          @(negedge clk);
          vld[0] = 1'b0;
          repeat (39) @(negedge clk);
          tx_data = bl[1];
          vld[0] = 1'b1;
          @(negedge clk);
          vld[0] = 1'b0;
        end
      end
    join
    e_line = 0;
    e_done = 0;
    rlow = 0;
    for (int s = 0; s < SN; s++) begin
      expb = 1'b1;
      expd = 1'b0;
      if (s >= 1 && s <= 40 * nf) begin
        f = (s - 1) / 40;
        c = ((s - 1) % 40) / NB;
        if (c == 0) expb = 1'b0;
        else if (c == 9) expb = 1'b1;
        else expb = bl[f][c - 1];
        expd = ((s % 40) == 0);
      end
      if (lt[s] !== expb) e_line++;
      if (ld[s] !== expd) e_done++;
      if (lr[s] !== 1'b1) rlow++;
    end
    chkn($sformatf("seq%0d_timeout", mode), tmo, 0);
    chkn($sformatf("seq%0d_line_bad_cycles", mode), e_line, 0);
    chkn($sformatf("seq%0d_done_bad_cycles", mode), e_done, 0);
    chkn($sformatf("seq%0d_ready_low_cycles", mode), rlow,
         exp_rlow);
  endtask

  task automatic reset_test();
    int dseen;
    int hseen;
    tx_data = 8'h00;
    vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    @(negedge clk);
    // now in start-bit cycle 0; bit 3 spans cycles 16..19
    repeat (18) @(negedge clk);
    chk1("rst_pre_tx", txv[0], 1'b0);
    chk1("rst_pre_busy", busyv[0], 1'b1);
    #1 rst = 1'b0;
    #1;
    chk1("rst_async_tx", txv[0], 1'b1);
    chk1("rst_async_busy", busyv[0], 1'b0);
    chk1("rst_async_ready", rdyv[0], 1'b1);
    @(negedge clk);
    rst = 1'b1;
    dseen = 0;
    hseen = 0;
    repeat (50) begin
      @(negedge clk);
      if (donev[0] !== 1'b0) dseen++;
      if (txv[0] !== 1'b1) hseen++;
    end
    chkn("rst_no_done", dseen, 0);
    chkn("rst_line_idle", hseen, 0);
    chk1("rst_after_ready", rdyv[0], 1'b1);
    chk1("rst_after_busy", busyv[0], 1'b0);
    run_vec(vt[1], 100);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    // frame = {stop(s), [parity], data, start}, hand-computed
    vt[0] = '{0, 8'hA5, 12'b00_1_10100101_0, 10};
    vt[1] = '{0, 8'h5A, 12'b00_1_01011010_0, 10};
    vt[2] = '{1, 8'h07, 12'b0_1_1_00000111_0, 11};
    vt[3] = '{2, 8'h07, 12'b0_1_0_00000111_0, 11};
    vt[4] = '{1, 8'h00, 12'b0_1_0_00000000_0, 11};
    vt[5] = '{2, 8'h00, 12'b0_1_1_00000000_0, 11};
    vt[6] = '{3, 8'h3C, 12'b0_1_1_00111100_0, 11};
    vt[7] = '{1, 8'h80, 12'b0_1_1_10000000_0, 11};
    vt[8] = '{2, 8'hFF, 12'b0_1_1_11111111_0, 11};

    rst = 1'b0;
    vld = 4'b0000;
    tx_data = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk1($sformatf("reset_tx%0d", i), txv[i], 1'b1);
      chk1($sformatf("reset_ready%0d", i), rdyv[i], 1'b1);
      chk1($sformatf("reset_busy%0d", i), busyv[i], 1'b0);
      chk1($sformatf("reset_done%0d", i), donev[i], 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_vec(vt[i], i);
      repeat (2) @(negedge clk);
    end

    seq_test(0);
    repeat (2) @(negedge clk);
    seq_test(1);
    repeat (2) @(negedge clk);
    reset_test();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-oriented UART transmitter, the transmit-side companion of our UART receiver. It accepts 8-bit words over a valid/ready handshake and serialises them on a single line as start bit, 8 data bits LSB first, optional parity, and 1 or 2 stop bits. Bit period is a fixed number of `clk` cycles. A one-entry holding register lets the producer queue the next byte while the current frame shifts out, so back-to-back frames have no idle gap.

## Interface
- `CLKS_PER_BIT`, default 434: clk cycles per bit (50 MHz / 115200); legal range ≥ 2.
- `PARITY_EN`, default 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: 1 or 2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `tx_data` in 8: byte to send; sampled on handshake.
- `tx_valid` in 1: producer has a byte.
- `tx_ready` out 1: holding register empty; handshake when `tx_valid && tx_ready` at a rising edge.
- `tx` out 1: serial line, idle high; registered.
- `tx_busy` out 1: FSM not in IDLE.
- `tx_done` out 1: one-cycle pulse in the last cycle of the final stop bit.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Registers: 8-bit shifter, 3-bit bit index, baud counter of width $clog2(CLKS_PER_BIT), 1-bit stop index, parity accumulator, 8-bit holding register plus full flag.
- IDLE: `tx`=1. On handshake, the byte loads directly into the shifter, bypassing the holding register. The FSM then enters START and the parity accumulator clears.
- START: `tx`=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: `tx`=shifter[0] for CLKS_PER_BIT cycles.
  - At each bit end: shift right, XOR the sent bit into parity, increment the index.
  - After index 7: go to PARITY if `PARITY_EN`, else STOP.
- PARITY: `tx` = accumulated XOR ^ `PARITY_ODD`, for CLKS_PER_BIT cycles.
- STOP: `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - At end, holding full: move holding into the shifter, clear full, enter START. No idle cycle.
  - At end, holding empty: enter IDLE.
- Handshake while FSM busy: the byte goes to the holding register and full is set.
- `tx_ready` = !full. A byte is never accepted while full.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at every bit boundary. It resets to 0 on each state entry.
- Frame length: (10 + PARITY_EN + STOP_BITS − 1) × CLKS_PER_BIT cycles.

## Timing
- Reset values: `tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0. FSM=IDLE, holding empty, all counters 0.
- Reset asserted mid-frame: `tx` returns high immediately (asynchronously). The current frame and any held byte are discarded, with no `tx_done`.
- Handshake at edge k while IDLE: `tx` falls after edge k+1 and `tx_busy`=1 from k+1. The start bit lasts exactly CLKS_PER_BIT cycles.
- Data bit i occupies cycles [(1+i)·N, (2+i)·N) relative to the start-bit first cycle, where N=CLKS_PER_BIT.
- `tx_done` is high in exactly one cycle per frame: the last cycle of the final stop bit.
- Stop end and a new handshake at the same edge:
  - If the holding register is empty, the handshake is taken as an IDLE-path direct load, so START follows with no gap.
  - If the holding register is full, `tx_ready`=0 and the byte is not accepted.
- `tx_ready` falls the cycle after a busy-time handshake. It rises the cycle after the holding register drains into the shifter.
- `tx_data` is don't-care outside handshake cycles.

## Test plan
- Reset, N=4, no parity, 1 stop: send 0xA5 from IDLE. The line shows 0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles. `tx_done` pulses in cycle 39 after the start bit begins; `tx_busy` is high for 40 cycles.
- Back-to-back: 0x00 then 0xFF, second offered while the first shifts. `tx_ready` drops for one frame. The second start bit begins in the cycle after the first stop bit ends, with no idle gap. Exactly two `tx_done` pulses.
- `PARITY_EN`=1: 0x07 with even parity gives parity bit 1; with `PARITY_ODD`=1 it gives 0. 0x00 with even parity gives parity bit 0. Frame length is 44 cycles at N=4.
- `STOP_BITS`=2, N=4: 0x3C. The stop high lasts 8 cycles, and `tx_done` is on the 8th stop cycle.
- Holding full: a third byte held on `tx_valid` while two are queued is not accepted until `tx_ready` returns. All three bytes appear in order with no loss or duplication.
- Reset asserted in DATA bit 3: `tx`=1 immediately with no `tx_done`. After release, `tx_ready`=1, `tx_busy`=0, and the next byte is sent intact.
